// File: rtl/pulse_wire_pkg.sv
// pulse_wire_pkg: constants and handshake typedefs shared by the mkReg/mkWire/mkPulse family.
package pulse_wire_pkg;

    localparam int CNT_W_DEF = 32;

    typedef struct packed {
        logic val;
        logic valid;
        logic consumed;
    } hs_bit_t;

endpackage

// File: rtl/pulse_wire_hs_monitor.sv
// hs_monitor: counts delivered transfers and flags valid/consumed handshake violations.
module hs_monitor #(
    parameter int DW    = 1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    data_i,
    input  logic             valid_i,
    input  logic             consumed_i,
    input  logic             fire_i,
    output logic [CNT_W-1:0] count_o,
    output logic             err_valid_drop_o,
    output logic             err_data_change_o
);
    logic [CNT_W-1:0] count_q, count_d;
    logic [DW-1:0]    held_q, held_d;
    logic             pend_q, pend_d;
    logic             drop_q, drop_d;
    logic             chg_q, chg_d;

    always_comb begin
        count_d = fire_i ? count_q + 1'b1 : count_q;
        pend_d  = valid_i & ~consumed_i;
        held_d  = data_i;
        drop_d  = drop_q | (pend_q & ~valid_i);
        chg_d   = chg_q | (pend_q & valid_i & (data_i != held_q));
    end

    // Reset also clears the pending history so no violation spans a reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            held_q  <= '0;
            pend_q  <= 1'b0;
            drop_q  <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            held_q  <= held_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            chg_q   <= chg_d;
        end
    end

    assign count_o           = count_q;
    assign err_valid_drop_o  = drop_q;
    assign err_data_change_o = chg_q;
endmodule

// File: rtl/pulse_wire.sv
// pulse_wire: zero-latency single-bit pulse channel with a clocked handshake monitor.
module pulse_wire
    import pulse_wire_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_EN_WRITE,
    input  logic             IN_EN_WRITE_VALID,
    output logic             IN_EN_WRITE_CONSUMED,
    output logic             OUT_READ,
    output logic             OUT_READ_VALID,
    input  logic             OUT_READ_CONSUMED,
    output logic [CNT_W-1:0] PULSE_COUNT,
    output logic             ERR_VALID_DROP,
    output logic             ERR_DATA_CHANGE
);
    hs_bit_t ch;

    assign ch = '{val: IN_EN_WRITE, valid: IN_EN_WRITE_VALID, consumed: OUT_READ_CONSUMED};

    // Raw bit passes even when not valid; readers may use it directly.
    assign OUT_READ             = ch.val;
    assign OUT_READ_VALID       = ch.valid;
    assign IN_EN_WRITE_CONSUMED = ch.consumed;

    hs_monitor #(.DW(1), .CNT_W(CNT_W)) u_mon (
        .clk               (CLK),
        .rst_n             (RST_N),
        .data_i            (ch.val),
        .valid_i           (ch.valid),
        .consumed_i        (ch.consumed),
        .fire_i            (ch.val & ch.valid & ch.consumed),
        .count_o           (PULSE_COUNT),
        .err_valid_drop_o  (ERR_VALID_DROP),
        .err_data_change_o (ERR_DATA_CHANGE)
    );
endmodule

// File: tb/tb_pulse_wire.sv
// tb_pulse_wire: directed and random checks of pulse_wire against a transaction-level model.
module tb_pulse_wire;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w = 1'b0, v = 1'b0, c = 1'b0;
    logic          w_cons, r, r_val;
    logic [CW-1:0] cnt;
    logic          e_drop, e_chg;

    int checks = 0;
    int errors = 0;

    // Model: count of deliveries, and the outstanding unconsumed offer (if any).
    int   m_cnt = 0;
    bit   m_drop = 0, m_chg = 0;
    bit   offer_open = 0;
    logic offer_val = 1'b0;

    pulse_wire #(.CNT_W(CW)) dut (
        .CLK                  (clk),
        .RST_N                (rst_n),
        .IN_EN_WRITE          (w),
        .IN_EN_WRITE_VALID    (v),
        .IN_EN_WRITE_CONSUMED (w_cons),
        .OUT_READ             (r),
        .OUT_READ_VALID       (r_val),
        .OUT_READ_CONSUMED    (c),
        .PULSE_COUNT          (cnt),
        .ERR_VALID_DROP       (e_drop),
        .ERR_DATA_CHANGE      (e_chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rs, input logic wi, input logic vi, input logic ci);
        rst_n = rs; w = wi; v = vi; c = ci;
        #1;
        chk("out_read", r, wi);
        chk("out_read_valid", r_val, vi);
        chk("in_consumed", w_cons, ci);
        @(posedge clk);
        if (!rs) begin
            m_cnt = 0; m_drop = 0; m_chg = 0; offer_open = 0;
        end else begin
            if (wi && vi && ci) m_cnt = (m_cnt + 1) % (1 << CW);
            if (offer_open && !vi) m_drop = 1;
            if (offer_open && vi && wi != offer_val) m_chg = 1;
            offer_open = vi && !ci;
            offer_val  = wi;
        end
        #1;
        chk("pulse_count", 32'(cnt), 32'(m_cnt));
        chk("err_valid_drop", e_drop, m_drop);
        chk("err_data_change", e_chg, m_chg);
    endtask

    initial begin
        step(0, 1, 1, 1);
        step(0, 0, 1, 0);
        chk("reset_count", 32'(cnt), 0);
        chk("reset_drop", e_drop, 0);
        chk("reset_chg", e_chg, 0);
        step(1, 1, 1, 1);
        chk("pass_count", 32'(cnt), 1);
        repeat (10) step(1, 0, $urandom_range(0, 1), $urandom_range(0, 1));
        chk("idle_count", 32'(cnt), 1);
        step(1, 1, 0, 1);
        chk("novalid_count", 32'(cnt), 1);
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        chk("drop_set", e_drop, 1);
        chk("drop_no_chg", e_chg, 0);
        repeat (3) step(1, 0, 0, 0);
        chk("drop_sticky", e_drop, 1);
        step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        chk("chg_set", e_chg, 1);
        chk("chg_no_drop", e_drop, 0);
        step(0, 0, 0, 0);
        repeat (5) step(1, 1, 1, 1);
        step(1, 1, 1, 0);
        step(1, 0, 1, 1);
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        chk("pre_reset_count", 32'(cnt), 5);
        chk("pre_reset_drop", e_drop, 1);
        chk("pre_reset_chg", e_chg, 1);
        step(0, 1, 1, 1);
        chk("post_reset_count", 32'(cnt), 0);
        chk("post_reset_drop", e_drop, 0);
        chk("post_reset_chg", e_chg, 0);
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("no_err_across_reset", e_drop, 0);
        repeat (17) step(1, 1, 1, 1);
        chk("wrap_count", 32'(cnt), 1);
        repeat (400) step($urandom_range(0, 19) != 0, $urandom_range(0, 1),
                          $urandom_range(0, 1), $urandom_range(0, 1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
